// File: rtl/truth_table_sweeper.sv
// Sweeps all 128 input vectors through a 7-input Boolean function, captures its truth
// table, compares it with a golden table and streams the table out MSB nibble first.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned TT_BITS       = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TT_BITS-1:0] expected,
    output logic [6:0]         x_drv,
    input  logic               fn_out,
    output logic               busy,
    output logic [3:0]         nib_data,
    output logic               nib_valid,
    input  logic               nib_ready,
    output logic [TT_BITS-1:0] tt,
    output logic               tt_valid,
    output logic               match,
    output logic               done
);

    localparam int unsigned IDX_W   = 7;
    localparam int unsigned K_W     = 5;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SET_W   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned LAST_IX = 127;
    localparam int unsigned LAST_K  = 31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [K_W-1:0]     k_q, k_d, k_next;
    logic [TT_BITS-1:0] tt_q, tt_d;
    logic [TT_BITS-1:0] exp_q, exp_d;
    logic [6:0]         x_drv_q, x_drv_d;
    logic               busy_q, busy_d;
    logic [NIB_W-1:0]   nib_data_q, nib_data_d;
    logic               nib_valid_q, nib_valid_d;
    logic               tt_valid_q, tt_valid_d;
    logic               match_q, match_d;
    logic               done_q, done_d;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            k_q         <= '0;
            tt_q        <= '0;
            exp_q       <= '0;
            x_drv_q     <= '0;
            busy_q      <= 1'b0;
            nib_data_q  <= '0;
            nib_valid_q <= 1'b0;
            tt_valid_q  <= 1'b0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            k_q         <= k_d;
            tt_q        <= tt_d;
            exp_q       <= exp_d;
            x_drv_q     <= x_drv_d;
            busy_q      <= busy_d;
            nib_data_q  <= nib_data_d;
            nib_valid_q <= nib_valid_d;
            tt_valid_q  <= tt_valid_d;
            match_q     <= match_d;
            done_q      <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        k_d         = k_q;
        k_next      = k_q - K_W'(1);
        tt_d        = tt_q;
        exp_d       = exp_q;
        x_drv_d     = x_drv_q;
        busy_d      = busy_q;
        nib_data_d  = nib_data_q;
        nib_valid_d = nib_valid_q;
        tt_valid_d  = tt_valid_q;
        match_d     = match_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tt_d       = '0;
                    tt_valid_d = 1'b0;
                    match_d    = 1'b0;
                    exp_d      = expected;
                    idx_d      = '0;
                    settle_d   = SET_W'(SETTLE_CYCLES);
                    x_drv_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else begin
                    tt_d[idx_q] = fn_out;
                    if (idx_q == IDX_W'(LAST_IX)) begin
                        // First nibble is taken from tt_d so it includes the bit just sampled
                        k_d         = K_W'(LAST_K);
                        x_drv_d     = '0;
                        nib_valid_d = 1'b1;
                        nib_data_d  = tt_d[TT_BITS-1 -: NIB_W];
                        state_d     = S_STREAM;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        x_drv_d  = idx_q + IDX_W'(1);
                        settle_d = SET_W'(SETTLE_CYCLES);
                    end
                end
            end
            S_STREAM: begin
                if (nib_ready) begin
                    if (k_q == '0) begin
                        nib_valid_d = 1'b0;
                        nib_data_d  = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        tt_valid_d  = 1'b1;
                        match_d     = (tt_q == exp_q);
                        state_d     = S_DONE;
                    end else begin
                        k_d        = k_next;
                        nib_data_d = tt_q[{k_next, 2'b00} +: NIB_W];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign x_drv     = x_drv_q;
    assign busy      = busy_q;
    assign nib_data  = nib_data_q;
    assign nib_valid = nib_valid_q;
    assign tt        = tt_q;
    assign tt_valid  = tt_valid_q;
    assign match     = match_q;
    assign done      = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: combinational (SETTLE_CYCLES=0) and
// two-stage registered (SETTLE_CYCLES=2) function paths.
module tb_truth_table_sweeper;

    localparam logic [127:0] GOLD  = 128'hfeeefaeafee0c880feecf880a8a08880;
    localparam logic [127:0] ALT_A = {32{4'hA}};
    localparam logic [127:0] HALF  = {{64{1'b1}}, {64{1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: combinational function selected by fn_mode
    logic         start_a = 1'b0;
    logic [127:0] exp_a   = '0;
    logic         rdy_a   = 1'b1;
    logic [1:0]   fn_mode = 2'd0;
    logic [127:0] gold_v  = GOLD;
    logic [6:0]   a_x;
    logic         a_fn, a_busy, a_nv, a_ttv, a_match, a_done;
    logic [3:0]   a_nd;
    logic [127:0] a_tt;

    always_comb begin
        case (fn_mode)
            2'd1:    a_fn = a_x[0];
            2'd2:    a_fn = gold_v[a_x];
            default: a_fn = 1'b0;
        endcase
    end

    truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .x_drv(a_x), .fn_out(a_fn), .busy(a_busy),
        .nib_data(a_nd), .nib_valid(a_nv), .nib_ready(rdy_a),
        .tt(a_tt), .tt_valid(a_ttv), .match(a_match), .done(a_done)
    );

    // Instance B: function x6 registered twice
    logic         start_b = 1'b0;
    logic [127:0] exp_b   = '0;
    logic [6:0]   b_x;
    logic         b_r1, b_r2, b_busy, b_nv, b_ttv, b_match, b_done;
    logic [3:0]   b_nd;
    logic [127:0] b_tt;

    always_ff @(posedge clk) begin
        b_r1 <= b_x[6];
        b_r2 <= b_r1;
    end

    truth_table_sweeper #(.SETTLE_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .x_drv(b_x), .fn_out(b_r2), .busy(b_busy),
        .nib_data(b_nd), .nib_valid(b_nv), .nib_ready(1'b1),
        .tt(b_tt), .tt_valid(b_ttv), .match(b_match), .done(b_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one sweep on A; optionally stall nib_ready for bp_len cycles at nibble k == bp_k
    task automatic run_a(input logic [127:0] exp_tbl, input int bp_k, input int bp_len,
                         output int ncyc, output logic [127:0] got, output int nnib);
        int         stall;
        logic [3:0] held;
        bit         seen;
        stall = 0; held = '0; got = '0; nnib = 0; ncyc = 0; seen = 1'b0;
        @(negedge clk); start_a = 1'b1; exp_a = exp_tbl; rdy_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        while (!seen && ncyc < 3000) begin
            if (a_done) begin
                seen = 1'b1;
            end else begin
                if (ncyc == 5) check("x_drv_mid", 128'(a_x), 128'd5);
                if (ncyc == 128) begin
                    check("x_drv_stream", 128'(a_x), 128'd0);
                    check("nib_valid_entry", 128'(a_nv), 128'd1);
                end
                if (a_nv) begin
                    if (31 - nnib == bp_k && stall > 0) check("nib_hold", 128'(a_nd), 128'(held));
                    if (31 - nnib == bp_k && stall < bp_len) begin
                        held  = a_nd;
                        rdy_a = 1'b0;
                        stall++;
                    end else begin
                        rdy_a = 1'b1;
                        got   = {got[123:0], a_nd};
                        nnib++;
                    end
                end
                @(negedge clk); ncyc++;
            end
        end
        if (!seen) check("done_timeout", 128'd0, 128'd1);
        rdy_a = 1'b1;
    endtask

    task automatic check_a_done(input string tag, input logic [127:0] exp_tt, input logic exp_match);
        check({tag, "_tt"}, a_tt, exp_tt);
        check({tag, "_match"}, 128'(a_match), 128'(exp_match));
        check({tag, "_ttv"}, 128'(a_ttv), 128'd1);
        check({tag, "_busy"}, 128'(a_busy), 128'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(a_done), 128'd0);
    endtask

    initial begin
        int           ncyc, nnib, n;
        logic [127:0] got;
        logic [127:0] got_b;

        #12;
        check("rst_tt", a_tt, 128'd0);
        check("rst_flags", {a_busy, a_nv, a_ttv, a_match, a_done}, 128'd0);
        check("rst_x_nib", {a_x, a_nd}, 128'd0);
        @(negedge clk); rst = 1'b0;

        // 1: function tied low
        fn_mode = 2'd0;
        run_a(128'd0, -1, 0, ncyc, got, nnib);
        check("t1_cycles", 128'(ncyc), 128'd160);
        check("t1_nibs", got, 128'd0);
        check("t1_count", 128'(nnib), 128'd32);
        check_a_done("t1", 128'd0, 1'b1);

        // 2: function = x0
        fn_mode = 2'd1;
        run_a(ALT_A, -1, 0, ncyc, got, nnib);
        check("t2_nibs", got, ALT_A);
        check_a_done("t2", ALT_A, 1'b1);

        // 3: golden function, then the same with a corrupted expected bit
        fn_mode = 2'd2;
        run_a(GOLD, -1, 0, ncyc, got, nnib);
        check("t3_nibs", got, GOLD);
        check("t3_cycles", 128'(ncyc), 128'd160);
        check_a_done("t3", GOLD, 1'b1);
        run_a(GOLD ^ 128'd1, -1, 0, ncyc, got, nnib);
        check_a_done("t3_flip", GOLD, 1'b0);

        // 5: backpressure at k=20 for 5 cycles
        run_a(GOLD, 20, 5, ncyc, got, nnib);
        check("t5_cycles", 128'(ncyc), 128'd165);
        check("t5_nibs", got, GOLD);
        check("t5_count", 128'(nnib), 128'd32);
        check_a_done("t5", GOLD, 1'b1);

        // 4: two settle cycles through a twice-registered x6
        @(negedge clk); start_b = 1'b1; exp_b = HALF;
        @(negedge clk); start_b = 1'b0;
        ncyc = 0; got_b = '0; nnib = 0;
        while (!b_done && ncyc < 3000) begin
            if (b_nv) begin got_b = {got_b[123:0], b_nd}; nnib++; end
            @(negedge clk); ncyc++;
        end
        check("t4_cycles", 128'(ncyc), 128'd416);
        check("t4_tt", b_tt, HALF);
        check("t4_nibs", got_b, HALF);
        check("t4_match", 128'({b_match, b_ttv}), 128'd3);

        // 6: start ignored during DRIVE, reset mid-sweep, then a clean run
        fn_mode = 2'd1;
        @(negedge clk); start_a = 1'b1; exp_a = ALT_A;
        @(negedge clk); start_a = 1'b0;
        n = 0;
        while (n < 20) begin @(negedge clk); n++; end
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("t6_ignore_start", 128'(a_x), 128'd21);
        check("t6_busy", 128'(a_busy), 128'd1);
        n = 0;
        while (a_x != 7'd60 && n < 200) begin @(negedge clk); n++; end
        check("t6_reach60", 128'(a_x), 128'd60);
        rst = 1'b1;
        #1;
        check("t6_rst_tt", a_tt, 128'd0);
        check("t6_rst_flags", {a_busy, a_nv, a_ttv, a_match, a_done}, 128'd0);
        check("t6_rst_x_nib", {a_x, a_nd}, 128'd0);
        @(negedge clk); rst = 1'b0;
        run_a(ALT_A, -1, 0, ncyc, got, nnib);
        check("t6_cycles", 128'(ncyc), 128'd160);
        check("t6_nibs", got, ALT_A);
        check_a_done("t6", ALT_A, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
